// File: rtl/result_display.sv
// 8-bit result to 3-digit BCD via double dabble, multiplexed onto a 7-segment display; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: strobe sampled at edge N gives bcd/bcd_ready in cycle N+9; a queued value restarts one cycle after completion.
// Backpressure: none; strobes while busy land in a one-entry pending register, last strobe wins.
module result_display #(
    parameter int unsigned REFRESH_DIV = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  value,
    input  logic        value_valid,
    output logic        busy,
    output logic        bcd_ready,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  dig_sel
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(REFRESH_DIV - 1);

    state_t      state_q, state_d;
    logic        restart_q, restart_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] work_q, work_d;
    logic [11:0] bcd_q, bcd_d;
    logic        bcd_ready_q, bcd_ready_d;
    logic        pending_q, pending_d;
    logic [7:0]  pend_val_q, pend_val_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [2:0]  dig_sel_q, dig_sel_d;

    logic [11:0] adj;
    logic [19:0] shifted;
    logic [3:0]  digit;
    logic        blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Conversion FSM: a restart cycle loads the pending value without passing through IDLE
    always_comb begin
        state_d     = state_q;
        restart_d   = restart_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        work_d      = work_q;
        bcd_d       = bcd_q;
        bcd_ready_d = 1'b0;
        pending_d   = pending_q;
        pend_val_d  = pend_val_q;
        adj         = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};
        shifted     = {adj, bin_q} << 1;

        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    state_d   = SHIFT;
                    bin_d     = value;
                    work_d    = 12'h000;
                    cnt_d     = 3'd0;
                    restart_d = 1'b0;
                end
            end
            SHIFT: begin
                if (restart_q) begin
                    bin_d     = pend_val_q;
                    work_d    = 12'h000;
                    cnt_d     = 3'd0;
                    restart_d = 1'b0;
                    if (value_valid) begin
                        pend_val_d = value;
                        pending_d  = 1'b1;
                    end
                end else begin
                    bin_d  = shifted[7:0];
                    work_d = shifted[19:8];
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        bcd_d       = shifted[19:8];
                        bcd_ready_d = 1'b1;
                        if (pending_q || value_valid) begin
                            restart_d = 1'b1;
                            pending_d = 1'b0;
                            if (value_valid) pend_val_d = value;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (value_valid) begin
                        pend_val_d = value;
                        pending_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = (presc_q == PRESC_MAX) ? 16'd0 : presc_q + 16'd1;
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        digit     = bcd_q[3:0];
        dig_sel_d = 3'b110;
        blank     = 1'b0;
        case (idx_d)
            2'd1: begin
                digit     = bcd_q[7:4];
                dig_sel_d = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
                blank     = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`endif
            end
            2'd2: begin
                digit     = bcd_q[11:8];
                dig_sel_d = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
                blank     = (bcd_q[11:8] == 4'd0);
`endif
            end
            default: begin
                digit     = bcd_q[3:0];
                dig_sel_d = 3'b110;
            end
        endcase
        seg_d = blank ? 7'b0000000 : decode(digit);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            restart_q   <= 1'b0;
            cnt_q       <= 3'd0;
            bin_q       <= 8'h00;
            work_q      <= 12'h000;
            bcd_q       <= 12'h000;
            bcd_ready_q <= 1'b0;
            pending_q   <= 1'b0;
            pend_val_q  <= 8'h00;
            presc_q     <= 16'd0;
            idx_q       <= 2'd0;
            seg_q       <= 7'b0000000;
            dig_sel_q   <= 3'b110;
        end else begin
            state_q     <= state_d;
            restart_q   <= restart_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            work_q      <= work_d;
            bcd_q       <= bcd_d;
            bcd_ready_q <= bcd_ready_d;
            pending_q   <= pending_d;
            pend_val_q  <= pend_val_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dig_sel_q   <= dig_sel_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign bcd_ready = bcd_ready_q;
    assign bcd       = bcd_q;
    assign seg       = seg_q;
    assign dig_sel   = dig_sel_q;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with a fast refresh divider; build with or without LEADING_ZERO_BLANK_EN.
module tb_result_display;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  value = 8'h00;
    logic        value_valid = 1'b0;
    logic        busy;
    logic        bcd_ready;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  dig_sel;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    result_display #(.REFRESH_DIV(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy),
        .bcd_ready   (bcd_ready),
        .bcd         (bcd),
        .seg         (seg),
        .dig_sel     (dig_sel)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_digit(input logic [2:0] sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dig_sel === sel) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        value_valid = 1'b0;
        step(); step(); step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bcd_ready !== 1'b0) begin failures++; $display("FAIL reset_bcd_ready got=%b exp=0", bcd_ready); end
        checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
        checks++; if (dig_sel !== 3'b110) begin failures++; $display("FAIL reset_dig_sel got=%b exp=110", dig_sel); end
        checks++; if (seg !== SEG_BLANK) begin failures++; $display("FAIL reset_seg got=%b exp=0000000", seg); end
        reset = 1'b1;
        step();
        checks++; if (seg !== SEG_0) begin failures++; $display("FAIL first_seg got=%b exp=%b", seg, SEG_0); end
        checks++; if (dig_sel !== 3'b110) begin failures++; $display("FAIL first_dig_sel got=%b exp=110", dig_sel); end
    endtask

    task automatic test_convert_255();
        bit ok;
        value = 8'd255;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (busy !== ((c >= 1) && (c <= 8))) begin
                failures++; $display("FAIL busy_255 cycle=%0d got=%b", c, busy);
            end
            checks++;
            if (bcd_ready !== (c == 9)) begin
                failures++; $display("FAIL ready_255 cycle=%0d got=%b", c, bcd_ready);
            end
            if (c == 8) begin
                checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL hold_255 got=%h exp=000", bcd); end
            end
            if (c == 9) begin
                checks++; if (bcd !== 12'h255) begin failures++; $display("FAIL bcd_255 got=%h exp=255", bcd); end
            end
            step();
        end
        wait_digit(3'b011, ok);
        checks++; if (!ok || seg !== SEG_2) begin failures++; $display("FAIL seg_255_h ok=%b got=%b exp=%b", ok, seg, SEG_2); end
        wait_digit(3'b101, ok);
        checks++; if (!ok || seg !== SEG_5) begin failures++; $display("FAIL seg_255_t ok=%b got=%b exp=%b", ok, seg, SEG_5); end
        wait_digit(3'b110, ok);
        checks++; if (!ok || seg !== SEG_5) begin failures++; $display("FAIL seg_255_o ok=%b got=%b exp=%b", ok, seg, SEG_5); end
    endtask

    task automatic test_small_values();
        bit ok;
        logic [6:0] exp_lead;
`ifdef LEADING_ZERO_BLANK_EN
        exp_lead = SEG_BLANK;
`else
        exp_lead = SEG_0;
`endif
        value = 8'd7;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        for (int c = 1; c < 11; c++) step();
        checks++; if (bcd !== 12'h007) begin failures++; $display("FAIL bcd_7 got=%h exp=007", bcd); end
        wait_digit(3'b011, ok);
        checks++; if (!ok || seg !== exp_lead) begin failures++; $display("FAIL seg_7_h ok=%b got=%b exp=%b", ok, seg, exp_lead); end
        wait_digit(3'b101, ok);
        checks++; if (!ok || seg !== exp_lead) begin failures++; $display("FAIL seg_7_t ok=%b got=%b exp=%b", ok, seg, exp_lead); end
        wait_digit(3'b110, ok);
        checks++; if (!ok || seg !== SEG_7) begin failures++; $display("FAIL seg_7_o ok=%b got=%b exp=%b", ok, seg, SEG_7); end

        value = 8'd0;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        for (int c = 1; c < 11; c++) step();
        checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL bcd_0 got=%h exp=000", bcd); end
        wait_digit(3'b101, ok);
        checks++; if (!ok || seg !== exp_lead) begin failures++; $display("FAIL seg_0_t ok=%b got=%b exp=%b", ok, seg, exp_lead); end
        wait_digit(3'b110, ok);
        checks++; if (!ok || seg !== SEG_0) begin failures++; $display("FAIL seg_0_o ok=%b got=%b exp=%b", ok, seg, SEG_0); end
    endtask

    task automatic test_back_to_back();
        bit saw_42;
        saw_42 = 1'b0;
        value = 8'd100;
        value_valid = 1'b1;
        step();                       // cycle 1
        value_valid = 1'b0;
        step(); step();               // cycle 3
        value = 8'd42;
        value_valid = 1'b1;
        step();                       // cycle 4
        value_valid = 1'b0;
        step();                       // cycle 5
        value = 8'd13;
        value_valid = 1'b1;
        step();                       // cycle 6
        value_valid = 1'b0;
        for (int c = 6; c <= 20; c++) begin
            if (bcd === 12'h042) saw_42 = 1'b1;
            checks++;
            if (bcd_ready !== ((c == 9) || (c == 18))) begin
                failures++; $display("FAIL ready_b2b cycle=%0d got=%b", c, bcd_ready);
            end
            if (c == 9 || c == 17) begin
                checks++; if (bcd !== 12'h100) begin failures++; $display("FAIL bcd_100 cycle=%0d got=%h exp=100", c, bcd); end
            end
            if (c >= 11 && c <= 16) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_b2b cycle=%0d got=%b exp=1", c, busy); end
            end
            if (c == 18) begin
                checks++; if (bcd !== 12'h013) begin failures++; $display("FAIL bcd_13 got=%h exp=013", bcd); end
            end
            step();
        end
        checks++; if (saw_42) begin failures++; $display("FAIL no_42 got=seen exp=never"); end
    endtask

    task automatic test_reset_abort();
        value = 8'd200;
        value_valid = 1'b1;
        step();                       // cycle 1
        value_valid = 1'b0;
        step(); step(); step();       // cycle 4
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (bcd !== 12'h000 || busy !== 1'b0 || bcd_ready !== 1'b0) begin
                failures++; $display("FAIL abort cycle=%0d bcd=%h busy=%b ready=%b exp=000/0/0", c, bcd, busy, bcd_ready);
            end
            step();
        end
        value = 8'd64;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        for (int c = 1; c < 9; c++) step();
        checks++; if (bcd !== 12'h064 || bcd_ready !== 1'b1) begin failures++; $display("FAIL bcd_64 got=%h ready=%b exp=064/1", bcd, bcd_ready); end
    endtask

    task automatic test_refresh();
        bit ok1, ok2;
        logic [2:0] exp_sel;
        logic [6:0] exp_seg;
        logic [6:0] exp_h;
`ifdef LEADING_ZERO_BLANK_EN
        exp_h = SEG_BLANK;
`else
        exp_h = SEG_0;
`endif
        step(); step();
        wait_digit(3'b011, ok1);
        wait_digit(3'b101, ok2);
        checks++; if (!ok1 || !ok2) begin failures++; $display("FAIL refresh_sync got=%b%b exp=11", ok1, ok2); end
        for (int k = 0; k < 16; k++) begin
            case ((k / 4) % 3)
                0:       begin exp_sel = 3'b101; exp_seg = SEG_6; end
                1:       begin exp_sel = 3'b011; exp_seg = exp_h; end
                default: begin exp_sel = 3'b110; exp_seg = SEG_4; end
            endcase
            checks++;
            if (dig_sel !== exp_sel || seg !== exp_seg) begin
                failures++; $display("FAIL refresh k=%0d got=%b/%b exp=%b/%b", k, dig_sel, seg, exp_sel, exp_seg);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_convert_255();
        test_small_values();
        test_back_to_back();
        test_reset_abort();
        test_refresh();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
